// File: rtl/cgra_seq_pkg.sv
// Shared types for the CGRA config sequencer.
//   state_e        : sequencer FSM states
//   cfg_word_t     : buffered config word {last, addr, data}
//   expected_pad() : stim * scale truncated to pad_w bits (pad_w <= 32)
// ADDR_W / DATA_W on the top must not exceed CFG_ADDR_W / CFG_DATA_W.
package cgra_seq_pkg;

  localparam int CFG_ADDR_W = 32;
  localparam int CFG_DATA_W = 32;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, CHECK, DONE} state_e;

  typedef struct packed {
    logic                  last;
    logic [CFG_ADDR_W-1:0] addr;
    logic [CFG_DATA_W-1:0] data;
  } cfg_word_t;

  function automatic logic [31:0] expected_pad(input logic [31:0] stim,
                                               input int unsigned scale,
                                               input int unsigned pad_w);
    logic [31:0] prod;
    prod = stim * scale;
    if (pad_w < 32) prod = prod & ((32'd1 << pad_w) - 32'd1);
    return prod;
  endfunction

endpackage

// File: rtl/cgra_cfg_fifo.sv
// Synchronous FIFO for config words. Registered full/empty flags.
//   clk, rst   : clock, synchronous active-high reset (flushes contents)
//   push/wdata : write side, ignored when full
//   pop/rdata  : read side, rdata shows the head entry, pop ignored when empty
//   full/empty : registered status
module cgra_cfg_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count, count_d;
  logic             do_push, do_pop;

  // A push while full is dropped even if a pop frees a slot this cycle;
  // the full flag is registered so ready only rises the cycle after.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count_d = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_d;
      full  <= (count_d == (AW+1)'(DEPTH));
      empty <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/cgra_config_sequencer.sv
// CGRA config sequencer: buffers config words, replays them onto the
// CGRA config bus one per cycle, runs the array for a programmed cycle
// count, then checks NUM_CH output pads against stim * SCALE.
//   clk_in, reset_in          : clock, synchronous active-high reset
//   start_in, run_cycles_in   : start pulse, run length sampled at start
//   cfg_valid/ready/addr/data/last : config word input stream
//   config_addr/data_out      : to CGRA config port (addr 0 = no-op)
//   stim_in, resp_in          : input/output pad values, ch0 in LSBs
//   busy/done/pass_out, mismatch_count_out, cycle_count_out : status
// Build option: define CONT_CHECK_EN to also compare every RUN cycle in the
// settled second half of the run (remaining <= run_cycles/2).
module cgra_config_sequencer
  import cgra_seq_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int PAD_W      = 16,
  parameter int NUM_CH     = 1,
  parameter int CNT_W      = 32,
  parameter int SCALE      = 2
) (
  input  logic                    clk_in,
  input  logic                    reset_in,
  input  logic                    start_in,
  input  logic [CNT_W-1:0]        run_cycles_in,
  input  logic                    cfg_valid_in,
  output logic                    cfg_ready_out,
  input  logic [ADDR_W-1:0]       cfg_addr_in,
  input  logic [DATA_W-1:0]       cfg_data_in,
  input  logic                    cfg_last_in,
  output logic [ADDR_W-1:0]       config_addr_out,
  output logic [DATA_W-1:0]       config_data_out,
  input  logic [NUM_CH*PAD_W-1:0] stim_in,
  input  logic [NUM_CH*PAD_W-1:0] resp_in,
  output logic                    busy_out,
  output logic                    done_out,
  output logic                    pass_out,
  output logic [CNT_W-1:0]        mismatch_count_out,
  output logic [CNT_W-1:0]        cycle_count_out
);

  state_e                        state_q, state_d;
  cfg_word_t                     wr_word, rd_word;
  logic                          fifo_full, fifo_empty, pop, start_acc, sample;
  logic [CNT_W-1:0]              remain_q, mm_q, cc_q, n_mism;
  logic [CNT_W:0]                mm_sum;
  logic [ADDR_W-1:0]             caddr_q;
  logic [DATA_W-1:0]             cdata_q;
  logic [NUM_CH-1:0][PAD_W-1:0]  stim_a, resp_a;
  logic [NUM_CH-1:0]             mism;

  assign wr_word = '{last: cfg_last_in,
                     addr: CFG_ADDR_W'(cfg_addr_in),
                     data: CFG_DATA_W'(cfg_data_in)};

  cgra_cfg_fifo #(.WIDTH($bits(cfg_word_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk_in),
    .rst   (reset_in),
    .push  (cfg_valid_in),
    .wdata (wr_word),
    .pop   (pop),
    .rdata (rd_word),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Per-channel compare against the scaled stimulus
  assign stim_a = stim_in;
  assign resp_a = resp_in;

  always_comb begin
    mism   = '0;
    n_mism = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      mism[c] = (32'(resp_a[c]) != expected_pad(32'(stim_a[c]), SCALE, PAD_W));
      n_mism  = n_mism + CNT_W'(mism[c]);
    end
  end

  assign mm_sum = {1'b0, mm_q} + {1'b0, n_mism};

`ifdef CONT_CHECK_EN
  logic [CNT_W-1:0] run_len_q;
  assign sample = (state_q == CHECK) ||
                  (state_q == RUN && remain_q <= (run_len_q >> 1));
`else
  assign sample = (state_q == CHECK);
`endif

  // FSM
  always_ff @(posedge clk_in) begin
    if (reset_in) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE:  if (start_in) state_d = LOAD;
      LOAD:  if (!fifo_empty) begin
               pop = 1'b1;
               if (rd_word.last) state_d = RUN;
             end
      // RUN lasts max(run_cycles, 1) cycles
      RUN:   if (remain_q <= CNT_W'(1)) state_d = CHECK;
      CHECK: state_d = DONE;
      DONE:  if (start_in) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  assign start_acc = start_in && (state_q == IDLE || state_q == DONE);
  assign busy_out  = (state_q == LOAD) || (state_q == RUN) || (state_q == CHECK);

  // Datapath: config issue, run countdown, counters
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      caddr_q  <= '0;
      cdata_q  <= '0;
      remain_q <= '0;
      mm_q     <= '0;
      cc_q     <= '0;
`ifdef CONT_CHECK_EN
      run_len_q <= '0;
`endif
    end else begin
      caddr_q <= pop ? rd_word.addr[ADDR_W-1:0] : '0;
      cdata_q <= pop ? rd_word.data[DATA_W-1:0] : '0;
      if (start_acc) begin
        remain_q <= run_cycles_in;
        mm_q     <= '0;
        cc_q     <= '0;
`ifdef CONT_CHECK_EN
        run_len_q <= run_cycles_in;
`endif
      end else begin
        if (busy_out && !(&cc_q)) cc_q <= cc_q + CNT_W'(1);
        if (state_q == RUN && remain_q != '0) remain_q <= remain_q - CNT_W'(1);
        if (sample) mm_q <= mm_sum[CNT_W] ? '1 : mm_sum[CNT_W-1:0];
      end
    end
  end

  assign cfg_ready_out      = !fifo_full;
  assign config_addr_out    = caddr_q;
  assign config_data_out    = cdata_q;
  assign done_out           = (state_q == DONE);
  assign pass_out           = (state_q == DONE) && (mm_q == '0);
  assign mismatch_count_out = mm_q;
  assign cycle_count_out    = cc_q;

endmodule

// File: tb/tb_cgra_config_sequencer.sv
module tb_cgra_config_sequencer;

  localparam int NUM_CH = 2;
  localparam int PAD_W  = 16;
  localparam int CNT_W  = 32;

  logic                    clk = 1'b0;
  logic                    reset_in = 1'b0, start_in = 1'b0;
  logic [CNT_W-1:0]        run_cycles_in = '0;
  logic                    cfg_valid_in = 1'b0, cfg_last_in = 1'b0;
  logic                    cfg_ready_out;
  logic [31:0]             cfg_addr_in = '0, cfg_data_in = '0;
  logic [31:0]             config_addr_out, config_data_out;
  logic [NUM_CH*PAD_W-1:0] stim_in = '0, resp_in = '0;
  logic                    busy_out, done_out, pass_out;
  logic [CNT_W-1:0]        mismatch_count_out, cycle_count_out;

  always #5 clk = ~clk;

  cgra_config_sequencer #(.NUM_CH(NUM_CH), .PAD_W(PAD_W), .CNT_W(CNT_W)) dut (
    .clk_in(clk), .reset_in(reset_in), .start_in(start_in),
    .run_cycles_in(run_cycles_in), .cfg_valid_in(cfg_valid_in),
    .cfg_ready_out(cfg_ready_out), .cfg_addr_in(cfg_addr_in),
    .cfg_data_in(cfg_data_in), .cfg_last_in(cfg_last_in),
    .config_addr_out(config_addr_out), .config_data_out(config_data_out),
    .stim_in(stim_in), .resp_in(resp_in), .busy_out(busy_out),
    .done_out(done_out), .pass_out(pass_out),
    .mismatch_count_out(mismatch_count_out), .cycle_count_out(cycle_count_out)
  );

  typedef struct { logic [31:0] addr; logic [31:0] data; int cyc; } cfg_exp_t;
  typedef struct { logic pass; int mc; int cc; int cyc; } done_exp_t;

  cfg_exp_t  cfg_q[$];
  done_exp_t done_q[$];
  int checks = 0, errors = 0, cyc = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every non-zero config write and every rising done is scored
  always @(negedge clk) begin : mon
    cfg_exp_t  ce;
    done_exp_t de;
    if (config_addr_out !== '0) begin
      if (cfg_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL cfg_unexpected: got addr %0h data %0h expected no write",
                 config_addr_out, config_data_out);
      end else begin
        ce = cfg_q.pop_front();
        chk("cfg_addr", config_addr_out, ce.addr);
        chk("cfg_data", config_data_out, ce.data);
        if (ce.cyc >= 0) chk("cfg_cycle", cyc, ce.cyc);
      end
    end
    if (done_out === 1'b1 && prev_done !== 1'b1) begin
      if (done_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL done_unexpected: got done at cycle %0d expected none", cyc);
      end else begin
        de = done_q.pop_front();
        chk("pass", pass_out, de.pass);
        chk("mismatch_count", mismatch_count_out, de.mc);
        chk("cycle_count", cycle_count_out, de.cc);
        chk("done_cycle", cyc, de.cyc);
      end
    end
    prev_done <= done_out;
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic l, output int ep);
    cfg_valid_in = 1'b1; cfg_addr_in = a; cfg_data_in = d; cfg_last_in = l;
    tick;
    ep = cyc;
    cfg_valid_in = 1'b0; cfg_last_in = 1'b0;
  endtask

  task automatic start(input logic [31:0] run, output int e0);
    run_cycles_in = run; start_in = 1'b1;
    tick;
    e0 = cyc;
    start_in = 1'b0;
  endtask

  task automatic exp_cfg(input logic [31:0] a, input logic [31:0] d, input int c);
    cfg_exp_t e;
    e.addr = a; e.data = d; e.cyc = c;
    cfg_q.push_back(e);
  endtask

  task automatic exp_done(input logic p, input int mc, input int cc, input int c);
    done_exp_t e;
    e.pass = p; e.mc = mc; e.cc = cc; e.cyc = c;
    done_q.push_back(e);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done_out !== 1'b1 && n < 200) begin tick; n++; end
    if (done_out !== 1'b1) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no done expected done within 200 cycles", name);
    end
    tick; tick;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int e0, ep;
    // Reset state
    reset_in = 1'b1;
    tick; tick;
    chk("rst_ready", cfg_ready_out, 1);
    chk("rst_busy", busy_out, 0);
    chk("rst_done", done_out, 0);
    chk("rst_pass", pass_out, 0);
    chk("rst_mc", mismatch_count_out, 0);
    chk("rst_cc", cycle_count_out, 0);
    chk("rst_caddr", config_addr_out, 0);
    chk("rst_cdata", config_data_out, 0);
    reset_in = 1'b0;
    tick;

    // Single-word load, run 5: LOAD 1 + RUN 5 + CHECK 1
    stim_in = '0; resp_in = '0;
    push(32'h0001_0002, 32'hFF, 1'b1, ep);
    start(5, e0);
    exp_cfg(32'h0001_0002, 32'hFF, e0 + 1);
    exp_done(1'b1, 0, 7, e0 + 7);
    wait_done("single");

    // Full FIFO, then drain in order; two-channel pass case
    stim_in = 32'h0180_0003; resp_in = 32'h0300_0006;
    for (int i = 0; i < 8; i++) begin
      push(32'h100 + i, 32'hA0 + i, i == 7, ep);
      if (i == 6) chk("ready_7", cfg_ready_out, 1);
      if (i == 7) chk("ready_full", cfg_ready_out, 0);
    end
    start(2, e0);
    for (int i = 0; i < 8; i++) exp_cfg(32'h100 + i, 32'hA0 + i, e0 + 1 + i);
    exp_done(1'b1, 0, 11, e0 + 11);
    wait_done("full");
    chk("ready_drained", cfg_ready_out, 1);

    // Truncation: 0x8001*2 -> 0x0002
    stim_in = 32'h0000_8001; resp_in = 32'h0000_0002;
    push(32'h200, 32'h1, 1'b1, ep);
    start(1, e0);
    exp_cfg(32'h200, 32'h1, e0 + 1);
    exp_done(1'b1, 0, 3, e0 + 3);
    wait_done("trunc_pass");

    // Single mismatch
    resp_in = 32'h0000_0003;
    push(32'h204, 32'h2, 1'b1, ep);
    start(3, e0);
    exp_cfg(32'h204, 32'h2, e0 + 1);
    exp_done(1'b0, 1, 5, e0 + 5);
    wait_done("trunc_fail");

    // Zero run length, both channels mismatch
    resp_in = 32'h0001_0003;
    push(32'h208, 32'h3, 1'b1, ep);
    start(0, e0);
    exp_cfg(32'h208, 32'h3, e0 + 1);
    exp_done(1'b0, 2, 3, e0 + 3);
    wait_done("zero_run");

    // Start pulses during RUN are ignored
    stim_in = 32'h0180_0003; resp_in = 32'h0300_0006;
    push(32'h20C, 32'h4, 1'b1, ep);
    start(6, e0);
    exp_cfg(32'h20C, 32'h4, e0 + 1);
    exp_done(1'b1, 0, 8, e0 + 8);
    tick;
    start_in = 1'b1; tick; start_in = 1'b0; tick;
    start_in = 1'b1; tick; start_in = 1'b0;
    chk("run_busy", busy_out, 1);
    wait_done("start_ignored");

    // Reset in LOAD with 3 words still queued
    for (int i = 0; i < 4; i++) push(32'h300 + i, 32'hB0 + i, i == 3, ep);
    start(4, e0);
    exp_cfg(32'h300, 32'hB0, e0 + 1);
    tick;
    reset_in = 1'b1;
    tick;
    chk("mrst_caddr", config_addr_out, 0);
    chk("mrst_cdata", config_data_out, 0);
    chk("mrst_ready", cfg_ready_out, 1);
    chk("mrst_busy", busy_out, 0);
    chk("mrst_done", done_out, 0);
    chk("mrst_pass", pass_out, 0);
    chk("mrst_mc", mismatch_count_out, 0);
    chk("mrst_cc", cycle_count_out, 0);
    reset_in = 1'b0;
    tick;
    start(1, e0);
    repeat (4) tick;
    chk("wait_busy", busy_out, 1);
    chk("wait_done", done_out, 0);
    push(32'h400, 32'hC0, 1'b1, ep);
    exp_cfg(32'h400, 32'hC0, ep + 1);
    exp_done(1'b1, 0, ep - e0 + 3, ep + 3);
    wait_done("after_reset");

    chk("cfg_q_left", cfg_q.size(), 0);
    chk("done_q_left", done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
